// File: rtl/gray_step_arbiter.sv
// Round-robin owner of a shared 3-bit gray counter: runs N steps (optional clear first) per request.
// Define GRAY_OVF_TRACE_EN to add the OvfSeen sticky-overflow trace output.
module gray_step_arbiter #(
  parameter int STEP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic [STEP_W-1:0] Steps0,
  input  logic              Clr0,
  input  logic              Req1,
  input  logic [STEP_W-1:0] Steps1,
  input  logic              Clr1,
  input  logic [2:0]        GrayValue,
  input  logic              GrayOverflow,
  output logic              GrayEn,
  output logic              GrayReset,
  output logic [1:0]        Grant,
  output logic [1:0]        Done,
  output logic [2:0]        Result,
  output logic              Wrapped,
`ifdef GRAY_OVF_TRACE_EN
  output logic              OvfSeen,
`endif
  output logic              Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [STEP_W-1:0] r_remaining;
  logic [1:0]        r_grant;
  logic [2:0]        r_result;
  logic              r_wrapped;
  logic              r_lastServed;

  logic              w_anyReq;
  logic              w_winner;
  logic [STEP_W-1:0] w_winSteps;
  logic              w_winClr;

  // On contention the requester that was not served last wins.
  assign w_anyReq   = Req0 | Req1;
  assign w_winner   = (Req0 & Req1) ? ~r_lastServed : Req1;
  assign w_winSteps = w_winner ? Steps1 : Steps0;
  assign w_winClr   = w_winner ? Clr1 : Clr0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_anyReq) begin
          if (w_winClr) begin
            w_nextState = S_CLEAR;
          end else if (w_winSteps != '0) begin
            w_nextState = S_RUN;
          end else begin
            w_nextState = S_SETTLE;
          end
        end
      end
      S_CLEAR:  w_nextState = (r_remaining != '0) ? S_RUN : S_SETTLE;
      S_RUN:    w_nextState = (r_remaining == STEP_W'(1)) ? S_SETTLE : S_RUN;
      S_SETTLE: w_nextState = S_DONE;
      S_DONE:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Result is captured in SETTLE so the counter has already absorbed the final step.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_remaining  <= '0;
      r_grant      <= '0;
      r_result     <= '0;
      r_wrapped    <= 1'b0;
      r_lastServed <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_remaining <= w_winSteps;
            r_grant     <= w_winner ? 2'b10 : 2'b01;
            r_wrapped   <= 1'b0;
          end
        end
        S_RUN: begin
          r_remaining <= r_remaining - STEP_W'(1);
          if (GrayValue == 3'b100) begin
            r_wrapped <= 1'b1;
          end
        end
        S_SETTLE: r_result <= GrayValue;
        S_DONE: begin
          r_grant      <= '0;
          r_lastServed <= r_grant[1];
        end
        default: ;
      endcase
    end
  end

`ifdef GRAY_OVF_TRACE_EN
  logic r_ovfSeen;

  // An overflow in the same cycle as CLEAR wins over the clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ovfSeen <= 1'b0;
    end else if (GrayOverflow) begin
      r_ovfSeen <= 1'b1;
    end else if (r_state == S_CLEAR) begin
      r_ovfSeen <= 1'b0;
    end
  end

  assign OvfSeen = r_ovfSeen;
`else
  logic w_unusedOvf;
  assign w_unusedOvf = GrayOverflow;
`endif

  assign GrayEn    = (r_state == S_RUN);
  assign GrayReset = (r_state == S_CLEAR);
  assign Busy      = (r_state != S_IDLE);
  assign Grant     = r_grant;
  assign Done      = (r_state == S_DONE) ? r_grant : 2'b00;
  assign Result    = r_result;
  assign Wrapped   = r_wrapped;

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Bench for gray_step_arbiter: behavioural gray counter plus a transaction-level reference model.
// Define GRAY_OVF_TRACE_EN to also exercise OvfSeen.
module tb_gray_step_arbiter;

  localparam int STEP_W = 4;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Req0, Clr0, Req1, Clr1;
  logic [STEP_W-1:0] Steps0, Steps1;
  logic [2:0]        GrayValue;
  logic              GrayOverflow;
  logic              GrayEn, GrayReset, Wrapped, Busy;
  logic [1:0]        Grant, Done;
  logic [2:0]        Result;
`ifdef GRAY_OVF_TRACE_EN
  logic              OvfSeen;
`endif

  int total = 0;
  int bad   = 0;

  logic [2:0] cntBin;
  logic       cntOvf;
  int         refCount;
  int         refLast;

  always #5 Clk = ~Clk;

  gray_step_arbiter #(.STEP_W(STEP_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Steps0(Steps0), .Clr0(Clr0),
    .Req1(Req1), .Steps1(Steps1), .Clr1(Clr1),
    .GrayValue(GrayValue), .GrayOverflow(GrayOverflow),
    .GrayEn(GrayEn), .GrayReset(GrayReset),
    .Grant(Grant), .Done(Done), .Result(Result), .Wrapped(Wrapped),
`ifdef GRAY_OVF_TRACE_EN
    .OvfSeen(OvfSeen),
`endif
    .Busy(Busy)
  );

  // Shared counter: binary count presented in gray code, sticky overflow on 7 -> 0.
  always @(posedge Clk) begin
    if (Reset || GrayReset) begin
      cntBin <= 3'd0;
      cntOvf <= 1'b0;
    end else if (GrayEn) begin
      cntBin <= cntBin + 3'd1;
      if (cntBin == 3'd7) cntOvf <= 1'b1;
    end
  end

  assign GrayValue    = cntBin ^ (cntBin >> 1);
  assign GrayOverflow = cntOvf;

  function automatic logic [2:0] toGray(input int b);
    logic [2:0] v;
    v = 3'(b % 8);
    return v ^ (v >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    Reset = 1'b1;
    Req0 = 1'b0; Req1 = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    refCount = 0;
    refLast  = 1;
  endtask

  // Serves one or two requests and checks order, latency, result, wrap and pulse counts.
  task automatic applyStimulus(input bit r0, input bit r1, input int s0, input int s1,
                               input bit c0, input bit c1, input string tag);
    int         order[$];
    int         expDoneCyc[$];
    logic [2:0] expRes[$];
    bit         expWrap[$];
    int         cyc = 0, served = 0, enSeen = 0, rstSeen = 0;
    int         expEn = 0, expRst = 0, t = 0;
    bit         grantBad = 1'b0;
    if (r0 && r1) begin
      order.push_back(1 - refLast);
      order.push_back(refLast);
    end else begin
      order.push_back(r1 ? 1 : 0);
    end
    foreach (order[k]) begin
      int n     = order[k] ? s1 : s0;
      bit c     = order[k] ? c1 : c0;
      int start = c ? 0 : refCount;
      t = t + ((k == 0) ? 0 : 1) + (c ? 1 : 0) + n + 2;
      expDoneCyc.push_back(t);
      expRes.push_back(toGray(start + n));
      expWrap.push_back(start + n >= 8);
      refCount = (start + n) % 8;
      refLast  = order[k];
      expEn  += n;
      expRst += c ? 1 : 0;
    end

    @(negedge Clk);
    Req0 = r0; Req1 = r1;
    Steps0 = STEP_W'(s0); Steps1 = STEP_W'(s1);
    Clr0 = c0; Clr1 = c1;

    while (served < order.size() && cyc < 200) begin
      @(negedge Clk);
      cyc++;
      if (GrayEn) enSeen++;
      if (GrayReset) rstSeen++;
      if (Grant == 2'b11) grantBad = 1'b1;
      if (Done != 2'b00) begin
        checkOutput({tag, "_doneWho"}, 32'(Done), order[served] ? 2 : 1);
        checkOutput({tag, "_doneCycle"}, cyc, expDoneCyc[served]);
        checkOutput({tag, "_result"}, 32'(Result), 32'(expRes[served]));
        checkOutput({tag, "_wrapped"}, 32'(Wrapped), 32'(expWrap[served]));
        if (order[served] == 1) Req1 = 1'b0; else Req0 = 1'b0;
        served++;
      end
      if (served < order.size() && cyc == ((served == 0) ? 1 : expDoneCyc[0] + 2)) begin
        checkOutput({tag, "_grant"}, 32'(Grant), order[served] ? 2 : 1);
        checkOutput({tag, "_busy"}, 32'(Busy), 1);
        // Sampled-at-grant inputs are scrambled, and Req may drop, without affecting the run.
        if (order[served] == 1) begin
          Steps1 = STEP_W'($urandom); Clr1 = 1'($urandom);
          if ($urandom % 2 == 0) Req1 = 1'b0;
        end else begin
          Steps0 = STEP_W'($urandom); Clr0 = 1'($urandom);
          if ($urandom % 2 == 0) Req0 = 1'b0;
        end
      end
    end

    checkOutput({tag, "_servedAll"}, served, order.size());
    checkOutput({tag, "_enCycles"}, enSeen, expEn);
    checkOutput({tag, "_clrCycles"}, rstSeen, expRst);
    checkOutput({tag, "_grantOneHot"}, 32'(grantBad), 0);
    @(negedge Clk);
    checkOutput({tag, "_idleBusy"}, 32'(Busy), 0);
    checkOutput({tag, "_idleGrant"}, 32'(Grant), 0);
    checkOutput({tag, "_idleResultHeld"}, 32'(Result), 32'(expRes[order.size() - 1]));
  endtask

  initial begin
    bit sawDone;
    Reset = 1'b1;
    Req0 = 1'b0; Req1 = 1'b0; Clr0 = 1'b0; Clr1 = 1'b0;
    Steps0 = '0; Steps1 = '0;
    refCount = 0;
    refLast  = 1;
    repeat (3) @(negedge Clk);
    checkOutput("rst_grant", 32'(Grant), 0);
    checkOutput("rst_done", 32'(Done), 0);
    checkOutput("rst_result", 32'(Result), 0);
    checkOutput("rst_wrapped", 32'(Wrapped), 0);
    checkOutput("rst_busy", 32'(Busy), 0);
    checkOutput("rst_en", 32'(GrayEn), 0);
    Reset = 1'b0;

    applyStimulus(1'b1, 1'b0, 3, 0, 1'b1, 1'b0, "clr3");
    checkOutput("clr3_specResult", 32'(Result), 32'(3'b010));

    doReset();
    applyStimulus(1'b1, 1'b1, 2, 2, 1'b0, 1'b0, "both2");
    checkOutput("both2_specResult", 32'(Result), 32'(3'b110));

    applyStimulus(1'b0, 1'b1, 0, 9, 1'b0, 1'b1, "wrap9");
    checkOutput("wrap9_wrappedHeld", 32'(Wrapped), 1);

    applyStimulus(1'b1, 1'b0, 2, 0, 1'b1, 1'b0, "to011");
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, "zero");
    checkOutput("zero_specResult", 32'(Result), 32'(3'b011));

    // Reset lands in the second RUN cycle of a 5-step run.
    @(negedge Clk);
    Req0 = 1'b1; Steps0 = STEP_W'(5); Clr0 = 1'b0;
    @(negedge Clk);
    checkOutput("midrst_run1", 32'(GrayEn), 1);
    @(negedge Clk);
    Reset = 1'b1;
    Req0  = 1'b0;
    @(negedge Clk);
    checkOutput("midrst_en", 32'(GrayEn), 0);
    checkOutput("midrst_grant", 32'(Grant), 0);
    checkOutput("midrst_busy", 32'(Busy), 0);
    Reset = 1'b0;
    refCount = 0;
    refLast  = 1;
    sawDone = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      if (Done != 2'b00) sawDone = 1'b1;
    end
    checkOutput("midrst_noDone", 32'(sawDone), 0);
    applyStimulus(1'b1, 1'b1, 1, 4, 1'b0, 1'b1, "ptrAfterRst");

    for (int i = 0; i < 12; i++) begin
      bit rr0, rr1;
      rr0 = 1'($urandom);
      rr1 = 1'($urandom);
      if (!rr0 && !rr1) rr0 = 1'b1;
      applyStimulus(rr0, rr1, $urandom_range(0, 15), $urandom_range(0, 15),
                    1'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    end

`ifdef GRAY_OVF_TRACE_EN
    doReset();
    checkOutput("ovf_reset", 32'(OvfSeen), 0);
    applyStimulus(1'b1, 1'b0, 8, 0, 1'b1, 1'b0, "ovf8");
    checkOutput("ovf_seen", 32'(OvfSeen), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_step_arbiter.md
Name: gray_step_arbiter

Overview:
Shares one 3-bit gray-code counter between two requesters (0 and 1). Each request asks for N counter steps, optionally preceded by a counter clear. The block arbitrates round-robin and drives the counter's enable and clear inputs. It returns the final gray value and a wrap flag to the granted requester with a one-cycle Done pulse. It sits between client logic and the counter, and is the only driver of that counter's En and Reset inputs.

Parameters:
STEP_W, 4, width of step-count inputs; one request issues at most 2^STEP_W-1 steps.

Ports:
Clk  input  1  clock, rising edge.
Reset  input  1  synchronous, active-high; clock Clk.
Req0  input  1  request from requester 0; held high until Done[0].
Steps0  input  STEP_W  step count for requester 0; sampled at grant.
Clr0  input  1  requester 0 asks for a counter clear before stepping; sampled at grant.
Req1  input  1  request from requester 1.
Steps1  input  STEP_W  step count for requester 1.
Clr1  input  1  clear request for requester 1.
GrayValue  input  3  current counter output, combinational from counter state.
GrayOverflow  input  1  counter's sticky overflow flag.
GrayEn  output  1  counter enable, one step per cycle.
GrayReset  output  1  counter synchronous clear.
Grant  output  2  one-hot owner of the counter, registered.
Done  output  2  one-cycle completion pulse, bit = requester.
Result  output  3  gray value after the last step, registered.
Wrapped  output  1  counter passed 3'b100 -> 3'b000 during the current or last run, registered.
Busy  output  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, CLEAR, RUN, SETTLE, DONE. Busy = (state != IDLE).
- GrayReset = (state==CLEAR) and GrayEn = (state==RUN), both decoded combinationally from state.
- Reset:
  - state IDLE; Grant, Done, Result, Wrapped = 0.
  - Last-served pointer = 1, so requester 0 wins the first contention.
  - The counter's own reset is wired to system Reset externally.
- IDLE:
  - At an edge where any Req is high, select the winner:
    - If only one Req is high, that requester wins.
    - If both are high, the requester other than the last served wins.
  - Latch the winner's Steps into the remaining-step counter and latch its Clr.
  - Set Grant to the winner's one-hot bit and clear Wrapped.
  - Next state:
    - CLEAR if Clr=1.
    - Otherwise RUN if Steps != 0.
    - Otherwise SETTLE.
- CLEAR: lasts exactly 1 cycle. Next state is RUN if Steps != 0, otherwise SETTLE.
- RUN:
  - One GrayEn cycle per step; decrement remaining each cycle.
  - Leave for SETTLE at the edge where remaining goes 1 -> 0.
  - GrayEn is asserted for exactly N cycles.
- Wrap detect: in any RUN cycle where GrayValue == 3'b100, set Wrapped at that edge. It stays set until the next grant.
- SETTLE: 1 cycle; capture GrayValue into Result at its closing edge, after the counter has absorbed the last step.
- DONE:
  - Done[granted] = 1 for exactly this cycle, with Result and Wrapped stable.
  - At the closing edge: Grant -> 0, pointer -> served requester, state -> IDLE.
- Latency from the grant edge to the Done cycle start: (Clr ? 1 : 0) + N + 1 cycles, plus 1 for DONE.
  - Example: N=0, Clr=0 gives Done in the 2nd cycle after the grant edge.
- Req deassertion after grant is ignored; the run always completes.
- Req still high after Done is a new request. A requester cannot be granted on consecutive runs while the other is waiting.
- Steps/Clr changes after grant have no effect.
- Reset mid-operation: at the reset edge, state -> IDLE. GrayEn and GrayReset drop in the following cycle. No Done is issued and the pointer returns to 1.
- Result and Wrapped hold their values in IDLE until the next SETTLE or grant respectively.

Optional Feature:
GRAY_OVF_TRACE_EN:
- Defined: adds output OvfSeen (1 bit, registered, reset 0).
  - Set in any cycle where GrayOverflow == 1.
  - Cleared at the closing edge of a CLEAR state, unless GrayOverflow is 1 in that same cycle.
- Not defined: no OvfSeen port, and GrayOverflow is unused.

Test Plan:
- After reset, Req0=1, Steps0=3, Clr0=1 -> GrayReset 1 cycle, GrayEn 3 cycles, Done[0] pulse, Result=3'b010, Wrapped=0.
- Req0 and Req1 both high from reset, each Steps=2, Clr=0 -> Grant=2'b01 first with Result=3'b011, then Grant=2'b10 with Result=3'b110. Grant is never 2'b11.
- Req1, Steps1=9, Clr1=1 -> 9 GrayEn cycles, Wrapped=1, Result=3'b001.
- Counter at 3'b011, Req0 with Steps0=0, Clr0=0 -> no GrayEn, no GrayReset, Done[0] 2 cycles after the grant edge, Result=3'b011.
- Reset asserted in the 2nd RUN cycle of a 5-step run -> state IDLE, GrayEn low from the next cycle, Done never pulses, Grant=0.
- With GRAY_OVF_TRACE_EN, an 8-step run from 0 -> OvfSeen=1 after the wrap. A following Clr=1 run clears OvfSeen after CLEAR only if GrayOverflow is low during CLEAR.
